// File: rtl/mult_arbiter_pkg.sv
// Shared types and constants for the two-requester multiplier arbiter.
package mult_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam int TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/mult_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter; on a tie the requester other than the last one granted wins.
module rr_arbiter2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       grant_en_i,
    output logic       gnt_valid_o,
    output logic       gnt_id_o
);

    logic last_q;

    always_comb begin
        gnt_valid_o = |req_i;
        if (req_i == 2'b11) gnt_id_o = ~last_q;
        else                gnt_id_o = req_i[1];
    end

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                           last_q <= 1'b1;
        else if (grant_en_i && gnt_valid_o)  last_q <= gnt_id_o;
    end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one multiplier between two requesters: grant, start, wait for done/timeout, respond.
module mult_arbiter
    import mult_arbiter_pkg::*;
#(
    parameter int width   = 16,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 Req0,
    input  logic                 Req1,
    input  logic [width-1:0]     A0,
    input  logic [width-1:0]     B0,
    input  logic [width-1:0]     A1,
    input  logic [width-1:0]     B1,
    output logic                 Ack0,
    output logic                 Ack1,
    output logic [2*width-1:0]   Result,
    output logic                 ResultId,
    output logic                 ResultErr,
    output logic                 ResultValid,
    input  logic                 ResultReady,
    output logic                 MultBegin,
    output logic [width-1:0]     MultA,
    output logic [width-1:0]     MultB,
    input  logic [2*width-1:0]   MultProduct,
    input  logic                 MultDone
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic                 ack0_q, ack1_q, begin_q;
    logic [width-1:0]     mult_a_q, mult_b_q;
    logic [2*width-1:0]   result_q;
    logic                 id_q, err_q, valid_q;
    logic                 gnt_valid, gnt_id;

    rr_arbiter2 u_arb (
        .clk_i       (CLK),
        .rst_i       (RST),
        .req_i       ({Req1, Req0}),
        .grant_en_i  (state_q == ST_IDLE),
        .gnt_valid_o (gnt_valid),
        .gnt_id_o    (gnt_id)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            begin_q  <= 1'b0;
            mult_a_q <= '0;
            mult_b_q <= '0;
            result_q <= '0;
            id_q     <= 1'b0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        state_q  <= ST_START;
                        begin_q  <= 1'b1;
                        ack0_q   <= ~gnt_id;
                        ack1_q   <= gnt_id;
                        id_q     <= gnt_id;
                        mult_a_q <= gnt_id ? A1 : A0;
                        mult_b_q <= gnt_id ? B1 : B0;
                    end
                end
                ST_START: begin
                    state_q <= ST_BUSY;
                    begin_q <= 1'b0;
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                    cnt_q   <= '0;
                end
                ST_BUSY: begin
                    // cnt_q == 0 marks the first BUSY cycle, where a Done left over from the previous op is ignored.
                    if (cnt_q != '0 && MultDone) begin
                        state_q  <= ST_RESP;
                        result_q <= MultProduct;
                        err_q    <= 1'b0;
                        valid_q  <= 1'b1;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q  <= ST_RESP;
                        result_q <= '0;
                        err_q    <= 1'b1;
                        valid_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_RESP: begin
                    if (ResultReady) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign Ack0        = ack0_q;
    assign Ack1        = ack1_q;
    assign MultBegin   = begin_q;
    assign MultA       = mult_a_q;
    assign MultB       = mult_b_q;
    assign Result      = result_q;
    assign ResultId    = id_q;
    assign ResultErr   = err_q;
    assign ResultValid = valid_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a signed combinational multiplier model.
module tb_mult_arbiter;

    localparam int W  = 8;
    localparam int TO = 32;

    logic          CLK = 1'b0;
    logic          RST;
    logic          Req0, Req1;
    logic [W-1:0]  A0, B0, A1, B1;
    logic          Ack0, Ack1;
    logic [2*W-1:0] Result;
    logic          ResultId, ResultErr, ResultValid, ResultReady;
    logic          MultBegin;
    logic [W-1:0]  MultA, MultB;
    logic [2*W-1:0] MultProduct;
    logic          MultDone;

    int errors = 0;
    int checks = 0;
    int nbeg   = 0;

    mult_arbiter #(.width(W), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST), .Req0(Req0), .Req1(Req1),
        .A0(A0), .B0(B0), .A1(A1), .B1(B1),
        .Ack0(Ack0), .Ack1(Ack1), .Result(Result), .ResultId(ResultId),
        .ResultErr(ResultErr), .ResultValid(ResultValid), .ResultReady(ResultReady),
        .MultBegin(MultBegin), .MultA(MultA), .MultB(MultB),
        .MultProduct(MultProduct), .MultDone(MultDone)
    );

    always #5 CLK = ~CLK;

    assign MultProduct = $signed(MultA) * $signed(MultB);

    always @(posedge CLK) if (MultBegin) nbeg <= nbeg + 1;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        RST = 1'b1; Req0 = 0; Req1 = 0; A0 = 0; B0 = 0; A1 = 0; B1 = 0;
        ResultReady = 0; MultDone = 0;
        tick; tick;
        chk("rst_ack0", Ack0, 0);
        chk("rst_ack1", Ack1, 0);
        chk("rst_begin", MultBegin, 0);
        chk("rst_multa", MultA, 0);
        chk("rst_result", Result, 0);
        chk("rst_valid", ResultValid, 0);
        chk("rst_err", ResultErr, 0);
        RST = 1'b0;
        tick;

        // Basic op: 3*5, done in BUSY cycle 17
        Req0 = 1; A0 = 3; B0 = 5;
        tick;
        chk("t1_ack0", Ack0, 1);
        chk("t1_ack1", Ack1, 0);
        chk("t1_begin", MultBegin, 1);
        chk("t1_multa", MultA, 3);
        chk("t1_multb", MultB, 5);
        Req0 = 0;
        tick;
        chk("t1_begin_low", MultBegin, 0);
        chk("t1_ack0_low", Ack0, 0);
        for (int i = 0; i < 16; i++) tick;
        chk("t1_novalid_c17", ResultValid, 0);
        MultDone = 1;
        tick;
        MultDone = 0;
        chk("t1_valid", ResultValid, 1);
        chk("t1_result", Result, 15);
        chk("t1_id", ResultId, 0);
        chk("t1_err", ResultErr, 0);
        tick; tick; tick;
        chk("t1_valid_held", ResultValid, 1);
        chk("t1_result_held", Result, 15);
        chk("t1_one_begin", nbeg, 1);
        ResultReady = 1;
        tick;
        ResultReady = 0;
        chk("t1_valid_drop", ResultValid, 0);

        // Timeout: multiplier never completes
        Req1 = 1; A1 = 4; B1 = 4;
        tick;
        chk("to_ack1", Ack1, 1);
        Req1 = 0;
        tick;
        for (int i = 0; i < TO - 1; i++) tick;
        chk("to_novalid_last", ResultValid, 0);
        tick;
        chk("to_valid", ResultValid, 1);
        chk("to_err", ResultErr, 1);
        chk("to_result", Result, 0);
        chk("to_id", ResultId, 1);
        ResultReady = 1;
        tick;
        ResultReady = 0;

        // Next op after timeout, with Done stuck high from before (stale)
        MultDone = 1;
        Req0 = 1; A0 = 6; B0 = 7;
        tick;
        chk("st_ack0", Ack0, 1);
        Req0 = 0;
        tick;
        tick;
        chk("st_masked", ResultValid, 0);
        tick;
        chk("st_valid", ResultValid, 1);
        chk("st_result", Result, 42);
        chk("st_err", ResultErr, 0);
        MultDone = 0;
        ResultReady = 1;
        tick;
        ResultReady = 0;

        // Consumer stalls 10 cycles while Req1 waits
        Req0 = 1; A0 = 2; B0 = 9;
        tick;
        Req0 = 0;
        tick;
        MultDone = 1;
        tick;
        tick;
        MultDone = 0;
        chk("bp_valid", ResultValid, 1);
        chk("bp_result", Result, 18);
        Req1 = 1; A1 = 5; B1 = 5;
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("bp_noack1", Ack1, 0);
            chk("bp_result_stable", Result, 18);
            chk("bp_id_stable", ResultId, 0);
            chk("bp_valid_stable", ResultValid, 1);
        end
        ResultReady = 1;
        tick;
        ResultReady = 0;
        chk("bp_idle_noack1", Ack1, 0);
        chk("bp_idle_valid", ResultValid, 0);
        tick;
        chk("bp_ack1", Ack1, 1);
        chk("bp_multa", MultA, 5);
        Req1 = 0;
        tick;
        MultDone = 1;
        tick;
        tick;
        MultDone = 0;
        chk("bp2_result", Result, 25);
        chk("bp2_id", ResultId, 1);
        ResultReady = 1;
        tick;
        ResultReady = 0;

        // Reset in the middle of BUSY
        Req0 = 1; A0 = 7; B0 = 7;
        tick;
        Req0 = 0;
        tick; tick;
        RST = 1;
        #1;
        chk("mr_ack0", Ack0, 0);
        chk("mr_begin", MultBegin, 0);
        chk("mr_multa", MultA, 0);
        chk("mr_multb", MultB, 0);
        chk("mr_result", Result, 0);
        chk("mr_valid", ResultValid, 0);
        chk("mr_id", ResultId, 0);
        chk("mr_err", ResultErr, 0);
        tick;
        RST = 0;

        // Both requesting from reset: alternate 0,1,0,1
        Req0 = 1; Req1 = 1;
        A0 = 3; B0 = 4; A1 = 8'hFE; B1 = 7;
        ResultReady = 1; MultDone = 1;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            while (!(Ack0 || Ack1) && n < 10) begin tick; n++; end
            chk("rr_ack_seen", (Ack0 || Ack1), 1);
            chk("rr_grant_id", Ack1, g % 2);
            chk("rr_ack0_excl", Ack0, (g % 2 == 0) ? 1 : 0);
            n = 0;
            while (!ResultValid && n < 10) begin tick; n++; end
            chk("rr_valid_seen", ResultValid, 1);
            chk("rr_result_id", ResultId, g % 2);
            chk("rr_result", Result, (g % 2 == 1) ? 32'h0000FFF2 : 32'd12);
            tick;
        end
        Req0 = 0; Req1 = 0; MultDone = 0; ResultReady = 0;
        tick; tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter: width, default 16, operand width of the shared multiplier.
REQ-002 Parameter: TIMEOUT, default 64, maximum number of BUSY cycles to wait for MultDone.
REQ-003 CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 Req0, Req1  input  1 each  requester n has an operand pair pending; held until its Ack.
REQ-006 A0, B0, A1, B1  input  width each  multiplicand/multiplier of requester n; stable while Req high.
REQ-007 Ack0, Ack1  output  1 each  one-cycle pulse: operands of requester n are captured.
REQ-008 Result  output  2*width  captured product.
REQ-009 ResultId  output  1  index of the requester that owns Result.
REQ-010 ResultErr  output  1  result is a timeout, not a product.
REQ-011 ResultValid  output  1  Result, ResultId and ResultErr are valid.
REQ-012 ResultReady  input  1  consumer accepts the result.
REQ-013 MultBegin  output  1  start pulse to the shared multiplier.
REQ-014 MultA, MultB  output  width each  registered operands driven to the multiplier.
REQ-015 MultProduct  input  2*width  multiplier product.
REQ-016 MultDone  input  1  multiplier completion flag.

Function
REQ-017 FSM states: IDLE, START, BUSY, RESP.
REQ-018 IDLE: with any Req high, capture the granted operands into MultA/MultB, pulse its Ack, and go to START in the same cycle.
REQ-019 Arbitration: a single request wins; with both high, the requester other than last-granted wins (round robin); last-granted updates on every grant.
REQ-020 START: MultBegin=1 for exactly one cycle; clear cycle counter; go to BUSY.
REQ-021 BUSY: MultBegin=0; MultDone is ignored in the first BUSY cycle (stale Done masking); in a later cycle with MultDone=1, capture MultProduct into Result, ResultErr=0, go to RESP.
REQ-022 BUSY: the counter increments each cycle; when it reaches TIMEOUT-1 without MultDone, Result=0, ResultErr=1, go to RESP; MultDone and timeout in the same cycle resolve as MultDone.
REQ-023 RESP: ResultValid=1 and Result/ResultId/ResultErr held stable until ResultValid&ResultReady, then go to IDLE.
REQ-024 No new grant while in START/BUSY/RESP; requests stay pending, no Ack.
REQ-025 Earliest re-grant is the cycle after the ResultReady handshake (IDLE), giving a minimum per-op overhead of 3 cycles plus multiplier latency.
REQ-026 MultA/MultB change only on a grant.
REQ-027 Counter width is clog2(TIMEOUT); the counter saturates and never wraps.

Reset
REQ-028 RST high forces IDLE immediately, from any state including mid-BUSY; the in-flight operation is discarded with no result.
REQ-029 Reset values: Ack0=Ack1=0, MultBegin=0, MultA=MultB=0, Result=0, ResultId=0, ResultErr=0, ResultValid=0, counter=0, last-granted=1 (requester 0 wins the first tie).

Structure
REQ-030 A shared package holds the state enumeration (IDLE, START, BUSY, RESP) and the default TIMEOUT constant.
REQ-031 One sub-module, rr_arbiter2 (2-way round robin with last-granted register), is natural; the FSM, counter and registers stay in mult_arbiter.

Verification
REQ-032 Req0=1, A0=3, B0=5, model Done at BUSY cycle 17 -> Ack0 pulse, one MultBegin pulse, Result=15, ResultId=0, ResultErr=0, ResultValid held until ResultReady.
REQ-033 Req0=Req1=1 from reset, both held, ResultReady=1 -> grant order 0,1,0,1; A1=-2, B1=7 (signed) -> Result=-14 on the ResultId=1 response.
REQ-034 Model never asserts Done -> ResultErr=1 and Result=0 after exactly TIMEOUT BUSY cycles; next request is served normally.
REQ-035 MultDone left high from a previous op -> not sampled in the first BUSY cycle; Result taken from the new completion.
REQ-036 RST pulsed mid-BUSY -> all outputs at reset values within the same cycle, no ResultValid, next grant goes to requester 0.
REQ-037 ResultReady=0 for 10 cycles in RESP -> Result/ResultId stable, a Req1 arriving meanwhile gets no Ack until after the handshake.
